seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 105 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with tear-free word updates.
// Each digit slot lasts DIV cycles. The anodes stay dark for the first DEAD
// cycles of every slot. A word offered by the host is parked in a pending
// register. It becomes active only at the frame wrap, so every frame shows
// one consistent word.
// Optional feature: define SEG7_LZB_EN to blank leading-zero digits.
module seg7_scan_ctrl #(
  parameter int unsigned DIV  = 100000,
  parameter int unsigned DEAD = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  digit,
  output logic [1:0]  sel,
  output logic [3:0]  k,
  output logic        frame_start
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [15:0]     active_q, active_d;
  logic [15:0]     pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            frame_start_q, frame_start_d;

  logic slot_end;
  logic wrap;
  logic accept;

  assign slot_end = (cnt_q == CntW'(DIV - 1));
  assign wrap     = slot_end && (sel_q == 2'd3);
  assign accept   = in_valid && !pend_vld_q;

  // Next-state: scan counters, pending handoff and frame pulse.
  always_comb begin
    cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
    sel_d         = slot_end ? sel_q + 2'd1 : sel_q;
    active_d      = active_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    frame_start_d = wrap;
    // Promotion needs the flag set and acceptance needs it clear, so the two
    // never coincide; a word accepted on the wrap waits for the next wrap.
    if (wrap && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = in_data;
      pend_vld_d = 1'b1;
    end
  end

  // State register with synchronous reset; reset drops any pending word.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      sel_q         <= 2'd0;
      active_q      <= 16'h0000;
      pend_q        <= 16'h0000;
      pend_vld_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    logic blank;
    digit = 4'h0;
    unique case (sel_q)
      2'd0: digit = active_q[3:0];
      2'd1: digit = active_q[7:4];
      2'd2: digit = active_q[11:8];
      2'd3: digit = active_q[15:12];
      default: digit = 4'h0;
    endcase
    blank = (cnt_q < CntW'(DEAD));
`ifdef SEG7_LZB_EN
    // Slot n goes dark when nibbles n..3 are all zero; slot 0 always shows.
    unique case (sel_q)
      2'd3: blank = blank || (active_q[15:12] == 4'h0);
      2'd2: blank = blank || (active_q[15:8] == 8'h00);
      2'd1: blank = blank || (active_q[15:4] == 12'h000);
      default: blank = blank;
    endcase
`endif
    k           = blank ? 4'b1111 : ~(4'b0001 << sel_q);
    sel         = sel_q;
    in_ready    = !pend_vld_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (DIV=4, DEAD=1). The stimulus process
// pushes the expected outputs for every cycle it drives. A monitor on the
// falling edge pops each entry and compares it with the DUT outputs.
module tb_seg7_scan_ctrl;

  localparam int unsigned DIV  = 4;
  localparam int unsigned DEAD = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  digit;
  logic [1:0]  sel;
  logic [3:0]  k;
  logic        frame_start;

  always #5 clock = ~clock;

  seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .digit       (digit),
    .sel         (sel),
    .k           (k),
    .frame_start (frame_start)
  );

  typedef struct {
    int         t;
    logic [3:0] k;
    logic [3:0] digit;
    logic [1:0] sel;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   t        = 0;

  // Expected outputs at cycle tt (counted from reset release) with word w shown.
  function automatic exp_t make_exp(input int tt, input logic [15:0] w, input logic rdy);
    exp_t       e;
    int         s;
    int         c;
    logic [3:0] one;
    one   = 4'b0001;
    s     = (tt / DIV) % 4;
    c     = tt % DIV;
    e.t   = tt;
    e.sel = 2'(s);
    e.digit = w[4*s +: 4];
    e.k   = (c < DEAD) ? 4'b1111 : ~(one << s);
`ifdef SEG7_LZB_EN
    if ((s == 3 && w[15:12] == 4'h0) || (s == 2 && w[15:8] == 8'h00) ||
        (s == 1 && w[15:4] == 12'h000)) e.k = 4'b1111;
`endif
    e.fs  = (tt % (4 * DIV) == 0) && (tt > 0);
    e.rdy = rdy;
    return e;
  endfunction

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input logic [15:0] w, input logic rdy);
    sb_q.push_back(make_exp(t, w, rdy));
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic check(input string name, input int tt, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h want=%h", name, tt, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare mid-cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("k", e.t, k, e.k);
      check("digit", e.t, digit, e.digit);
      check("sel", e.t, {2'b00, sel}, {2'b00, e.sel});
      check("frame_start", e.t, {3'b000, frame_start}, {3'b000, e.fs});
      check("in_ready", e.t, {3'b000, in_ready}, {3'b000, e.rdy});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d got=running want=finished", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    t     = 0;

    // Frame 0: reset state, blank digits, anode sequence.
    for (int i = 0; i < 16; i++) cyc(16'h0000, 1'b1);

    // Frame 1: load 1234 at sel=1, then hold ABCD under back-pressure.
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        in_valid = 1'b1;
        in_data  = 16'h1234;
      end else if (i >= 5) begin
        in_valid = 1'b1;
        in_data  = 16'hABCD;
      end else begin
        in_valid = 1'b0;
      end
      cyc(16'h0000, (i <= 4));
    end

    // Frame 2: 1234 shown; ABCD taken on the first cycle.
    for (int i = 0; i < 16; i++) begin
      if (i == 1) in_valid = 1'b0;
      cyc(16'h1234, (i == 0));
    end

    // Frame 3: ABCD shown; 5678 offered on the wrap cycle.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        in_valid = 1'b1;
        in_data  = 16'h5678;
      end else begin
        in_valid = 1'b0;
      end
      cyc(16'hABCD, 1'b1);
    end

    // Frame 4: old value persists while 5678 waits.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b0;
      cyc(16'hABCD, 1'b0);
    end

    // Frame 5: 5678 shown; 0050 offered on the first cycle.
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        in_data  = 16'h0050;
      end else begin
        in_valid = 1'b0;
      end
      cyc(16'h5678, (i == 0));
    end

    // Frame 6: 0050 shown, leading zeros exercised.
    for (int i = 0; i < 16; i++) cyc(16'h0050, 1'b1);

    // Frame 7: 9999 pending, then reset at sel=2.
    for (int i = 0; i <= 8; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        in_data  = 16'h9999;
      end else begin
        in_valid = 1'b0;
      end
      if (i == 8) reset = 1'b1;
      cyc(16'h0050, (i == 0));
    end
    reset = 1'b0;
    t     = 0;

    // Two frames after reset: pending word discarded, no reset pulse.
    for (int i = 0; i < 32; i++) cyc(16'h0000, 1'b1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d want=0 pending entries", sb_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
